sd_stream_reader: RTL and testbench

- Sequencer in front of sd_cont's read path.
- On a start request it reads `sector_count` consecutive 512-byte sectors, beginning at `base_addr`.
- For each sector: pulse sd_read, wait for sd_cont to finish, then walk sd_index 0..511 and stream every buffered byte out on a valid/ready byte interface.
- Feeds loaders (e.g. program/data image into memory) that today hand-drive sd_read/sd_index.

---
 rtl/sd_stream_reader.sv | 131 +++++++++++++
 tb/tb_sd_stream_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_stream_reader.sv
// Sequencer in front of the sd_cont read path. It reads a run of 512-byte sectors
// and streams every buffered byte out on a valid/ready byte interface.
module sd_stream_reader #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [22:0]      base_addr,
   input  logic [CNT_W-1:0] sector_count,
   output logic             busy,
   output logic             done,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [22:0]      sd_addr,
   output logic             sd_read,
   output logic [8:0]       sd_index,
   input  logic [7:0]       sd_read_data,
   input  logic             sd_busy
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, GAP, WAITRD, FETCH, LOAD, PRESENT, FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [22:0]      sd_addr_q, sd_addr_d;
   logic             sd_read_q, sd_read_d;
   logic [8:0]       sd_index_q, sd_index_d;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sd_addr_d   = sd_addr_q;
      sd_read_d   = 1'b0;
      sd_index_d  = sd_index_q;
      case (state_q)
         IDLE: begin
            // busy stays high through the done cycle, drops here afterwards
            busy_d = 1'b0;
            if (start) begin
               sd_addr_d = base_addr;
               rem_d     = sector_count;
               busy_d    = 1'b1;
               state_d   = (sector_count == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            // a read may still be running from before a reset
            if (!sd_busy) begin
               sd_read_d  = 1'b1;
               sd_index_d = 9'd0;
               state_d    = GAP;
            end
         end
         GAP:    state_d = WAITRD;
         WAITRD: if (!sd_busy) state_d = FETCH;
         FETCH:  state_d = LOAD;
         LOAD: begin
            out_data_d  = sd_read_data;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
         end
         PRESENT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (sd_index_q != 9'd511) begin
                  sd_index_d = sd_index_q + 9'd1;
                  state_d    = FETCH;
               end else begin
                  rem_d = rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                     state_d = FINISH;
                  end else begin
                     sd_addr_d = sd_addr_q + 23'd1;
                     state_d   = ISSUE;
                  end
               end
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         sd_addr_q   <= 23'd0;
         sd_read_q   <= 1'b0;
         sd_index_q  <= 9'd0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sd_addr_q   <= sd_addr_d;
         sd_read_q   <= sd_read_d;
         sd_index_q  <= sd_index_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sd_addr   = sd_addr_q;
   assign sd_read   = sd_read_q;
   assign sd_index  = sd_index_q;

endmodule

// File: tb/tb_sd_stream_reader.sv
// Bench for sd_stream_reader: sd_cont stub with byte = (sector*7 + index) & 0xFF,
// a queue model of the expected byte stream and read addresses, and a per-cycle checker.
module tb_sd_stream_reader;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [22:0]      base_addr = '0;
   logic [CNT_W-1:0] sector_count = '0;
   logic             busy, done, out_valid, sd_read;
   logic             out_ready = 1'b1;
   logic [7:0]       out_data;
   logic [22:0]      sd_addr;
   logic [8:0]       sd_index;
   logic [7:0]       sd_read_data = 8'd0;
   logic             sd_busy;

   always #5 clk = ~clk;

   sd_stream_reader #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .sector_count(sector_count), .busy(busy), .done(done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .sd_addr(sd_addr), .sd_read(sd_read), .sd_index(sd_index),
      .sd_read_data(sd_read_data), .sd_busy(sd_busy)
   );

   function automatic logic [7:0] sec_byte(logic [22:0] s, int i);
      return 8'((int'(s) * 7 + i) & 255);
   endfunction

   // sd_cont stub: busy for 5 cycles after a read, registered buffer read
   int          bcnt = 0;
   logic [22:0] cur_sec = '0;
   logic        force_busy = 1'b0;
   assign sd_busy = force_busy | (bcnt != 0);
   always @(posedge clk) begin
      if (sd_read) begin
         cur_sec <= sd_addr;
         bcnt    <= 5;
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end
      sd_read_data <= sec_byte(cur_sec, int'(sd_index));
   end

   int total = 0, bad = 0;
   int cyc = 0, bytes_seen = 0, reads_k = 0, dones = 0, read_cyc = 0, fall_cyc = 0;
   int rdy_pct = 100;
   logic [7:0]  exp_bytes[$];
   logic [22:0] exp_addr[$];
   logic [7:0]  got[$];
   logic [22:0] rd_log[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_xfer(logic [22:0] base, int cnt);
      got.delete(); rd_log.delete();
      bytes_seen = 0; reads_k = 0; dones = 0;
      for (int s = 0; s < cnt; s++) begin
         exp_addr.push_back(base + 23'(s));
         for (int i = 0; i < 512; i++) exp_bytes.push_back(sec_byte(base + 23'(s), i));
      end
   endtask

   task automatic do_start(logic [22:0] base, int cnt);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; sector_count = CNT_W'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(int lim, string nm);
      int n = 0;
      while (!done && n < lim) begin
         @(posedge clk); #1; n++;
      end
      chk(nm, done, 1);
      @(negedge clk); #1;
   endtask

   task automatic wait_bytes(int cnt, int lim, string nm);
      int n = 0;
      while (bytes_seen < cnt && n < lim) begin
         @(posedge clk); #1; n++;
      end
      chk(nm, bytes_seen >= cnt, 1);
   endtask

   task automatic chk_reset_vals(string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_valid"}, out_valid, 0);
      chk({nm, "_data"}, out_data, 0);
      chk({nm, "_read"}, sd_read, 0);
      chk({nm, "_index"}, sd_index, 0);
      chk({nm, "_addr"}, sd_addr, 0);
   endtask

   // Per-cycle comparison of DUT outputs against the queue model
   task automatic checker_loop();
      logic prev_stall = 1'b0, prev_read = 1'b0, prev_done = 1'b0;
      logic [7:0] prev_data = '0;
      logic [8:0] prev_idx = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_bytes.delete(); exp_addr.delete();
            prev_stall = 1'b0; prev_read = 1'b0; prev_done = 1'b0;
         end else begin
            if (prev_done) chk("busy_after_done", busy, 0);
            if (done) begin
               chk("done_busy", busy, 1);
               chk("done_bytes_left", exp_bytes.size(), 0);
               chk("done_reads_left", exp_addr.size(), 0);
               dones++;
            end
            if (sd_read) begin
               chk("read_one_cycle", prev_read, 0);
               chk("read_while_busy", sd_busy, 0);
               chk("read_gate", bytes_seen, 512 * reads_k);
               if (exp_addr.size() == 0) chk("read_unexpected", 1, 0);
               else chk("read_addr", sd_addr, exp_addr.pop_front());
               reads_k++;
               rd_log.push_back(sd_addr);
               read_cyc = cyc;
            end
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, prev_data);
               chk("stall_index", sd_index, prev_idx);
            end
            if (out_valid && out_ready) begin
               if (exp_bytes.size() == 0) chk("byte_unexpected", 1, 0);
               else chk("byte", out_data, exp_bytes.pop_front());
               got.push_back(out_data);
               bytes_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = sd_index;
            prev_read  = sd_read;
            prev_done  = done;
         end
      end
   endtask

   initial begin
      fork
         checker_loop();
         forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;

      // single sector, no backpressure
      expect_xfer(23'h10, 1);
      do_start(23'h10, 1);
      wait_done(3000, "t1_done");
      chk("t1_count", got.size(), 512);
      chk("t1_first", got[0], 8'h70);
      chk("t1_last", got[511], 8'h6F);
      chk("t1_reads", rd_log.size(), 1);
      chk("t1_addr", rd_log[0], 23'h10);
      chk("t1_dones", dones, 1);
      @(posedge clk); #1;
      chk("t1_busy_low", busy, 0);

      // two sectors, 30% ready duty
      rdy_pct = 30;
      expect_xfer(23'h100, 2);
      do_start(23'h100, 2);
      wait_done(20000, "t2_done");
      rdy_pct = 100;
      chk("t2_count", got.size(), 1024);
      chk("t2_reads", rd_log.size(), 2);
      chk("t2_addr1", rd_log[1], 23'h101);
      chk("t2_byte512", got[512], 8'h07);

      // zero sectors
      expect_xfer(23'h5, 0);
      do_start(23'h5, 0);
      chk("t3_done_early", done, 0);
      chk("t3_busy", busy, 1);
      @(posedge clk); #1;
      chk("t3_done", done, 1);
      @(posedge clk); #1;
      chk("t3_done_off", done, 0);
      chk("t3_busy_off", busy, 0);
      @(negedge clk); #1;
      chk("t3_reads", rd_log.size(), 0);
      chk("t3_bytes", got.size(), 0);
      chk("t3_dones", dones, 1);

      // start while busy is ignored
      expect_xfer(23'h40, 1);
      do_start(23'h40, 1);
      wait_bytes(100, 2000, "t4_reach100");
      start = 1'b1; base_addr = 23'h55; sector_count = CNT_W'(3);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3000, "t4_done");
      chk("t4_count", got.size(), 512);
      chk("t4_first", got[0], 8'hC0);
      repeat (50) @(posedge clk);
      #1;
      chk("t4_dones", dones, 1);
      chk("t4_reads", rd_log.size(), 1);
      chk("t4_idle", busy, 0);

      // reset mid-stream, then a start that must wait out sd_busy
      expect_xfer(23'h20, 1);
      do_start(23'h20, 1);
      wait_bytes(300, 2000, "t5_reach300");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_vals("t5_rst");
      force_busy = 1'b1;
      expect_xfer(23'h30, 1);
      do_start(23'h30, 1);
      repeat (18) @(posedge clk);
      #1;
      chk("t5_no_read_busy", rd_log.size(), 0);
      force_busy = 1'b0;
      fall_cyc = cyc;
      wait_done(3000, "t5_done");
      chk("t5_read_after_fall", read_cyc > fall_cyc, 1);
      chk("t5_addr", rd_log[0], 23'h30);
      chk("t5_count", got.size(), 512);

      // address wrap
      expect_xfer(23'h7FFFFF, 2);
      do_start(23'h7FFFFF, 2);
      wait_done(5000, "t6_done");
      chk("t6_addr0", rd_log[0], 23'h7FFFFF);
      chk("t6_addr1", rd_log[1], 23'h0);
      chk("t6_count", got.size(), 1024);
      chk("t6_first", got[0], 8'hF9);
      chk("t6_byte512", got[512], 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
